// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer placed after uart_rx: captures every done-tick byte
// and lets the consumer pop at its own pace, with full/empty/count/sticky-overflow status.
module uart_rx_fifo #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wr,
    input  logic [B-1:0] i_wdata,
    input  logic         i_rd,
    input  logic         i_ovf_clr,
    output logic [B-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full,
    output logic [W:0]   o_count,
    output logic         o_overflow
);

    localparam int DEPTH = 1 << W;
    localparam logic [W:0] DEPTH_CNT = (W+1)'(DEPTH);

    logic [B-1:0] mem_q [DEPTH];

    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         overflow_q, overflow_d;

    logic empty, full;
    logic wr_accept, rd_accept, wr_drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    // A write into a full FIFO is still accepted when a pop frees a slot on the same edge.
    always_comb begin
        rd_accept  = i_rd && !empty;
        wr_accept  = i_wr && (!full || i_rd);
        wr_drop    = i_wr && full && !i_rd;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop on the same edge as a clear must leave the flag set.
        if (i_ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (wr_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    assign o_rdata    = empty ? '0 : mem_q[rd_ptr_q];
    assign o_empty    = empty;
    assign o_full     = full;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus pushes expected popped bytes into a queue,
// a negedge monitor checks every accepted pop, and status is compared against hand values.
module tb_uart_rx_fifo;

    logic       i_clk;
    logic       i_reset;
    logic       i_wr;
    logic [7:0] i_wdata;
    logic       i_rd;
    logic       i_ovf_clr;
    logic [7:0] o_rdata;
    logic       o_empty;
    logic       o_full;
    logic [2:0] o_count;
    logic       o_overflow;

    int asserts_evaluated = 0;
    int failures = 0;

    logic [7:0] exp_q [$];

    uart_rx_fifo #(.B(8), .W(2)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr       (i_wr),
        .i_wdata    (i_wdata),
        .i_rd       (i_rd),
        .i_ovf_clr  (i_ovf_clr),
        .o_rdata    (o_rdata),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Inputs change 2 time units after the rising edge, so the negedge sees the values
    // that the coming rising edge will act on.
    always @(negedge i_clk) begin
        if (i_reset && i_rd && !o_empty) begin
            asserts_evaluated++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL pop_unexpected: got %02h, no pop was expected", o_rdata);
            end else begin
                logic [7:0] exp_byte;
                exp_byte = exp_q.pop_front();
                if (o_rdata !== exp_byte) begin
                    failures++;
                    $display("[TB] FAIL pop_data: got %02h, expected %02h", o_rdata, exp_byte);
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [7:0] wdata,
                                 input logic rd, input logic clr);
        i_wr      = wr;
        i_wdata   = wdata;
        i_rd      = rd;
        i_ovf_clr = clr;
        @(posedge i_clk);
        #2;
        i_wr      = 1'b0;
        i_wdata   = 8'h00;
        i_rd      = 1'b0;
        i_ovf_clr = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic e, input logic f,
                               input logic [2:0] cnt, input logic ovf, input logic [7:0] data);
        logic [13:0] act, exp;
        act = {o_empty, o_full, o_count, o_overflow, o_rdata};
        exp = {e, f, cnt, ovf, data};
        asserts_evaluated++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got empty=%b full=%b count=%0d ovf=%b rdata=%02h, expected empty=%b full=%b count=%0d ovf=%b rdata=%02h",
                     name, o_empty, o_full, o_count, o_overflow, o_rdata, e, f, cnt, ovf, data);
        end
    endtask

    initial begin
        i_reset   = 1'b0;
        i_wr      = 1'b0;
        i_wdata   = 8'h00;
        i_rd      = 1'b0;
        i_ovf_clr = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        checkOutput("reset_state", 1, 0, 3'd0, 0, 8'h00);

        // Pops on an empty FIFO must be ignored.
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("empty_rd_ignored", 1, 0, 3'd0, 0, 8'h00);

        // Single-cycle done-tick pulses as uart_rx would present them.
        applyStimulus(1, 8'h55, 0, 0);
        checkOutput("rx_byte1", 0, 0, 3'd1, 0, 8'h55);
        repeat (3) applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(1, 8'hA3, 0, 0);
        checkOutput("rx_byte2", 0, 0, 3'd2, 0, 8'h55);
        exp_q.push_back(8'h55);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("rx_pop1", 0, 0, 3'd1, 0, 8'hA3);
        exp_q.push_back(8'hA3);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("rx_pop2", 1, 0, 3'd0, 0, 8'h00);

        // Fill on consecutive cycles, then overflow.
        applyStimulus(1, 8'h01, 0, 0);
        applyStimulus(1, 8'h02, 0, 0);
        applyStimulus(1, 8'h03, 0, 0);
        applyStimulus(1, 8'h04, 0, 0);
        checkOutput("fill_full", 0, 1, 3'd4, 0, 8'h01);
        applyStimulus(1, 8'h05, 0, 0);
        checkOutput("overflow_drop", 0, 1, 3'd4, 1, 8'h01);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("ovf_clear", 0, 1, 3'd4, 0, 8'h01);
        applyStimulus(1, 8'h05, 0, 1);
        checkOutput("ovf_set_wins", 0, 1, 3'd4, 1, 8'h01);

        // Full with simultaneous write and pop: both accepted, flag untouched.
        exp_q.push_back(8'h01);
        applyStimulus(1, 8'hAA, 1, 0);
        checkOutput("full_wr_rd", 0, 1, 3'd4, 1, 8'h02);

        exp_q.push_back(8'h02);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("drain1", 0, 0, 3'd3, 1, 8'h03);
        exp_q.push_back(8'h03);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("drain2", 0, 0, 3'd2, 1, 8'h04);
        exp_q.push_back(8'h04);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("drain3", 0, 0, 3'd1, 1, 8'hAA);
        exp_q.push_back(8'hAA);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("drain_empty", 1, 0, 3'd0, 1, 8'h00);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("ovf_clear2", 1, 0, 3'd0, 0, 8'h00);

        // Pointers wrap past the last slot.
        applyStimulus(1, 8'h06, 0, 0);
        applyStimulus(1, 8'h07, 0, 0);
        checkOutput("wrap_write", 0, 0, 3'd2, 0, 8'h06);
        exp_q.push_back(8'h06);
        applyStimulus(0, 8'h00, 1, 0);
        exp_q.push_back(8'h07);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("wrap_drained", 1, 0, 3'd0, 0, 8'h00);

        // Empty with simultaneous write and pop: only the write takes effect.
        applyStimulus(1, 8'h5C, 1, 0);
        checkOutput("empty_wr_rd", 0, 0, 3'd1, 0, 8'h5C);
        exp_q.push_back(8'h5C);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("empty_wr_rd_pop", 1, 0, 3'd0, 0, 8'h00);

        // Asynchronous reset between edges with three bytes stored.
        applyStimulus(1, 8'h11, 0, 0);
        applyStimulus(1, 8'h22, 0, 0);
        applyStimulus(1, 8'h33, 0, 0);
        checkOutput("pre_async_reset", 0, 0, 3'd3, 0, 8'h11);
        #1;
        i_reset = 1'b0;
        #1;
        checkOutput("async_reset", 1, 0, 3'd0, 0, 8'h00);
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        applyStimulus(1, 8'h3C, 0, 0);
        checkOutput("post_reset_write", 0, 0, 3'd1, 0, 8'h3C);
        exp_q.push_back(8'h3C);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("post_reset_pop", 1, 0, 3'd0, 0, 8'h00);

        repeat (2) @(posedge i_clk);
        asserts_evaluated++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL pops_outstanding: got %0d unconsumed expected pops, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_evaluated, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of uart_rx.
- Captures each byte presented with o_rx_done_tick/o_dout, so the single-cycle done pulse is never lost.
- Stores up to 2^W bytes, first-word-fall-through (FWFT).
- The consumer (command/ALU interface logic) pops bytes at its own pace. Full, empty, occupancy and sticky-overflow status are exported.

Parameters:
- B, 8: data width in bits; matches uart_rx o_dout.
- W, 2: address width; depth = 2^W entries (default 4).

Ports:
- i_clk  in  1  system clock; same clock as uart_rx and mod_m_counter.
- i_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_wr  in  1  write strobe; connect to uart_rx o_rx_done_tick; one-cycle pulse per byte.
- i_wdata  in  B  write data; connect to uart_rx o_dout; sampled on the i_clk edge where i_wr=1.
- i_rd  in  1  pop strobe from consumer; one entry removed per cycle with i_rd=1.
- i_ovf_clr  in  1  synchronous clear of o_overflow.
- o_rdata  out  B  head-of-queue byte (FWFT); 0 while o_empty=1.
- o_empty  out  1  1 when count = 0.
- o_full  out  1  1 when count = 2^W.
- o_count  out  W+1  number of stored entries, 0..2^W.
- o_overflow  out  1  sticky; set when a write is dropped because the FIFO is full.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - write pointer, read pointer and count go to 0.
  - o_empty=1, o_full=0, o_count=0, o_overflow=0, o_rdata=0.
  - Storage array is not reset.
  - Reset released mid-operation: FIFO restarts empty; previously stored bytes are unreachable.
- Storage: 2^W x B register array, written on the rising edge of i_clk.
- Pointers:
  - W-bit wr_ptr and rd_ptr wrap modulo 2^W (3 -> 0 at default).
  - Count is a separate (W+1)-bit register.
  - o_full and o_empty are registered, or decoded from count; both must reflect state after the edge.
- Write accepted when i_wr=1 and (o_full=0 or i_rd=1). Effect: mem[wr_ptr] <= i_wdata, wr_ptr++.
- Read accepted when i_rd=1 and o_empty=0. Effect: rd_ptr++.
- Cycle-level outcomes:
  - write only: count+1.
  - read only: count-1.
  - write and read both accepted: count unchanged.
  - neither accepted: no change.
- Full and i_wr=1 and i_rd=1: both accepted; byte stored in the slot freed this cycle; o_full stays 1; no overflow.
- Full and i_wr=1 and i_rd=0: write dropped; data and pointers unchanged; o_overflow <= 1 on that edge.
- Empty and i_rd=1: read ignored; no pointer move, no underflow state.
  - If i_wr=1 in the same cycle, the write is accepted and count becomes 1.
- o_overflow:
  - Stays 1 until i_ovf_clr=1 (cleared on that edge).
  - If a drop and i_ovf_clr occur in the same cycle, set wins (o_overflow=1).
- FWFT timing:
  - o_rdata = mem[rd_ptr] combinationally when o_empty=0, else 0.
  - A byte written at edge N is visible on o_rdata and o_empty=0 after edge N (zero-cycle read latency, one-cycle write-to-visible latency).
  - After a pop at edge N, o_rdata shows the next entry, or 0 if the FIFO is now empty.
- No combinational path from i_wr/i_wdata to any output; outputs depend only on registered state.
- i_rd must be driven only by consumer logic on i_clk.
- i_wr is assumed to be a single-cycle pulse, but consecutive-cycle writes must also work (one entry per cycle).

Test Plan:
- Reset/idle:
  - Hold i_reset=0 for 3 cycles, release.
  - Required: o_empty=1, o_full=0, o_count=0, o_overflow=0, o_rdata=8'h00.
  - Assert i_rd=1 for 2 cycles: state unchanged.
- End-to-end with uart_rx + mod_m_counter (M=5, N=8):
  - Serial-drive 8'h55, then 8'hA3, each with a stop bit.
  - Required: after the first o_rx_done_tick, o_count=1 and o_rdata=8'h55; after the second, o_count=2 and o_rdata still 8'h55.
  - Pulse i_rd: o_rdata=8'hA3, o_count=1.
- Fill, overflow and wrap (W=2):
  - Write 8'h01,02,03,04 on consecutive cycles: o_full=1, o_count=4.
  - Write 8'h05 with i_rd=0: dropped, o_overflow=1.
  - Pop 4 times: sequence 01,02,03,04, then o_empty=1, o_rdata=0.
  - Write 8'h06, 8'h07 (pointers wrap): pops return 06, 07.
- Simultaneous read/write:
  - While full with 01..04, pulse i_wr (8'hAA) and i_rd together.
  - Required: o_count stays 4, o_full=1, o_overflow unchanged; pop order 02,03,04,AA.
  - While empty, pulse i_wr (8'h5C) and i_rd together: o_count=1, o_rdata=8'h5C.
- Overflow clear priority:
  - With o_overflow=1, pulse i_ovf_clr alone: o_overflow=0.
  - While full, pulse i_wr and i_ovf_clr together: o_overflow=1.
- Asynchronous reset mid-stream:
  - With o_count=3, drive i_reset=0 between clock edges.
  - Required: o_empty=1, o_count=0, o_rdata=0 immediately, before the next edge.
  - After release, write 8'h3C: o_rdata=8'h3C.
